// File: rtl/cam_capture_core_if.sv
// Pin and FIFO-side signal bundle for cam_capture_core; master is the core, slave is the camera/FIFO side.
// Names follow the board-level pin names so the bundle maps 1:1 onto the schematic.
interface cam_capture_core_if #(
  parameter int DW    = 8,
  parameter int PIX_W = 16
);
  logic             CAPON;
  logic             SNAP;
  logic [1:0]       MODE;
  logic             FIFOFULL;
  logic             FIFOWR;
  logic [PIX_W-1:0] FIFOIN;
  logic             FRAME_DONE;
  logic             OVERFLOW;
  logic             BUSY;
  logic             XCLK;
  logic             PCLK;
  logic             HREF;
  logic             VSYNC;
  logic [DW-1:0]    CAMDATA;

  modport master (
    input  CAPON, SNAP, MODE, FIFOFULL, PCLK, HREF, VSYNC, CAMDATA,
    output FIFOWR, FIFOIN, FRAME_DONE, OVERFLOW, BUSY, XCLK
  );

  modport slave (
    output CAPON, SNAP, MODE, FIFOFULL, PCLK, HREF, VSYNC, CAMDATA,
    input  FIFOWR, FIFOIN, FRAME_DONE, OVERFLOW, BUSY, XCLK
  );
endinterface

// File: rtl/cam_capture_core.sv
// Oversampling camera front end: packs byte pairs into pixels and writes whole frames; write lands SYNC_STG+1 CLK
// after the second byte's PCLK rise. No stall: a write meeting FIFOFULL is dropped and flagged on OVERFLOW.
module cam_capture_core #(
  parameter int XCLK_DIV = 4,
  parameter int DW       = 8,
  parameter int PIX_W    = 16,
  parameter int SYNC_STG = 2
) (
  input logic                CLK,
  input logic                RST,
  cam_capture_core_if.master bus
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_VS = 2'd1;
  localparam logic [1:0] S_FRAME   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam int            XW     = (XCLK_DIV > 2) ? $clog2(XCLK_DIV / 2) : 1;
  localparam logic [XW-1:0] X_WRAP = XW'(XCLK_DIV / 2 - 1);

  logic [1:0]                  state_q, state_d;
  logic                        single_q, single_d;
  logic [1:0]                  mode_q, mode_d;
  logic [XW-1:0]               xcnt_q, xcnt_d;
  logic                        xclk_q, xclk_d;
  logic [SYNC_STG-1:0]         pclk_sy_q, pclk_sy_d;
  logic [SYNC_STG-1:0]         href_sy_q, href_sy_d;
  logic [SYNC_STG-1:0]         vs_sy_q, vs_sy_d;
  logic [SYNC_STG-1:0][DW-1:0] dat_sy_q, dat_sy_d;
  logic                        pclk_prev_q, pclk_prev_d;
  logic                        href_prev_q, href_prev_d;
  logic                        vs_prev_q, vs_prev_d;
  logic                        phase_q, phase_d;
  logic [DW-1:0]               b0_q, b0_d;
  logic [PIX_W-1:0]            pix_q, pix_d;
  logic [PIX_W-1:0]            fifoin_q, fifoin_d;
  logic                        wr_pend_q, wr_pend_d;
  logic                        ovf_q, ovf_d;

  logic          pclk_s, href_s, vs_s;
  logic [DW-1:0] dat_s;
  logic          pclk_rise, href_fall, vs_rise, vs_fall;
  logic          sample, wr_sched, fifo_wr;

  assign pclk_s    = pclk_sy_q[SYNC_STG-1];
  assign href_s    = href_sy_q[SYNC_STG-1];
  assign vs_s      = vs_sy_q[SYNC_STG-1];
  assign dat_s     = dat_sy_q[SYNC_STG-1];
  assign pclk_rise = pclk_s & ~pclk_prev_q;
  assign href_fall = ~href_s & href_prev_q;
  assign vs_rise   = vs_s & ~vs_prev_q;
  assign vs_fall   = ~vs_s & vs_prev_q;
  assign sample    = (state_q == S_FRAME) && pclk_rise && href_s;
  assign wr_sched  = sample && phase_q;
  assign fifo_wr   = wr_pend_q && !bus.FIFOFULL;

  always_comb begin
    state_d     = state_q;
    single_d    = single_q;
    mode_d      = mode_q;
    xcnt_d      = xcnt_q + 1'b1;
    xclk_d      = xclk_q;
    pclk_sy_d   = {pclk_sy_q[SYNC_STG-2:0], bus.PCLK};
    href_sy_d   = {href_sy_q[SYNC_STG-2:0], bus.HREF};
    vs_sy_d     = {vs_sy_q[SYNC_STG-2:0], bus.VSYNC};
    dat_sy_d    = {dat_sy_q[SYNC_STG-2:0], bus.CAMDATA};
    pclk_prev_d = pclk_s;
    href_prev_d = href_s;
    vs_prev_d   = vs_s;
    phase_d     = phase_q;
    b0_d        = b0_q;
    pix_d       = pix_q;
    fifoin_d    = fifoin_q;
    wr_pend_d   = wr_sched;
    ovf_d       = ovf_q;

    if (xcnt_q == X_WRAP) begin
      xcnt_d = '0;
      xclk_d = ~xclk_q;
    end

    if (href_fall) begin
      phase_d = 1'b0;
    end else if (sample) begin
      phase_d = ~phase_q;
      if (!phase_q) b0_d = dat_s;
    end

    if (wr_sched) begin
      case (mode_q)
        2'b01:   pix_d = PIX_W'({b0_q[3:0], dat_s});
        2'b10:   pix_d = PIX_W'(b0_q);
        default: pix_d = PIX_W'({b0_q, dat_s});
      endcase
    end

    if (fifo_wr) fifoin_d = pix_q;
    if (wr_pend_q && bus.FIFOFULL) ovf_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.CAPON || bus.SNAP) begin
          state_d  = S_WAIT_VS;
          single_d = ~bus.CAPON;
        end
      end
      S_WAIT_VS: begin
        if (vs_fall) begin
          state_d = S_FRAME;
          mode_d  = bus.MODE;
          phase_d = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      S_FRAME: begin
        // VSYNC is tested as a level so a rise that lands on a write in flight is deferred, not lost.
        if (vs_s && !wr_pend_q && !wr_sched) state_d = S_DONE;
      end
      default: begin
        state_d = (!single_q && bus.CAPON) ? S_WAIT_VS : S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      single_q    <= 1'b0;
      mode_q      <= 2'b00;
      xcnt_q      <= '0;
      xclk_q      <= 1'b0;
      pclk_sy_q   <= '0;
      href_sy_q   <= '0;
      vs_sy_q     <= '0;
      dat_sy_q    <= '0;
      pclk_prev_q <= 1'b0;
      href_prev_q <= 1'b0;
      vs_prev_q   <= 1'b0;
      phase_q     <= 1'b0;
      b0_q        <= '0;
      pix_q       <= '0;
      fifoin_q    <= '0;
      wr_pend_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      single_q    <= single_d;
      mode_q      <= mode_d;
      xcnt_q      <= xcnt_d;
      xclk_q      <= xclk_d;
      pclk_sy_q   <= pclk_sy_d;
      href_sy_q   <= href_sy_d;
      vs_sy_q     <= vs_sy_d;
      dat_sy_q    <= dat_sy_d;
      pclk_prev_q <= pclk_prev_d;
      href_prev_q <= href_prev_d;
      vs_prev_q   <= vs_prev_d;
      phase_q     <= phase_d;
      b0_q        <= b0_d;
      pix_q       <= pix_d;
      fifoin_q    <= fifoin_d;
      wr_pend_q   <= wr_pend_d;
      ovf_q       <= ovf_d;
    end
  end

  // FIFOIN shows the new pixel in its write cycle and otherwise holds the last written one.
  assign bus.FIFOWR     = fifo_wr;
  assign bus.FIFOIN     = fifo_wr ? pix_q : fifoin_q;
  assign bus.FRAME_DONE = (state_q == S_DONE);
  assign bus.OVERFLOW   = ovf_q;
  assign bus.BUSY       = (state_q != S_IDLE);
  assign bus.XCLK       = xclk_q;
endmodule

// File: tb/tb_cam_capture_core.sv
// Bench for cam_capture_core: directed camera frames, a frame-level model that predicts which pixels
// must reach the FIFO, and a per-cycle compare of FIFOWR/FIFOIN/XCLK against it.
module tb_cam_capture_core;
  localparam int XCLK_DIV = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  cam_capture_core_if #(.DW(8), .PIX_W(16)) bus ();

  cam_capture_core #(.XCLK_DIV(XCLK_DIV), .DW(8), .PIX_W(16), .SYNC_STG(2)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] wr_log[$];
  logic [15:0] m_last = 16'h0;
  int          done_cnt = 0;
  int          xn = 0;
  bit          m_armed = 1'b0;
  bit          m_in_frame = 1'b0;
  logic [1:0]  m_mode = 2'b00;
  int          w0, w1, d0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] fmt(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
    case (m)
      2'b01:   return {4'h0, a[3:0], b};
      2'b10:   return {8'h00, a};
      default: return {a, b};
    endcase
  endfunction

  function automatic logic [15:0] last_wr();
    if (wr_log.size() == 0) return 16'hxxxx;
    return wr_log[wr_log.size()-1];
  endfunction

  // XCLK reference: edges since reset release, half-period XCLK_DIV/2 edges.
  always @(posedge CLK) xn <= RST ? xn + 1 : 0;

  always @(negedge CLK) begin
    if (!RST) begin
      chk("reset_outputs", {bus.FIFOWR, bus.FIFOIN, bus.FRAME_DONE, bus.OVERFLOW, bus.BUSY, bus.XCLK}, 32'h0);
    end else begin
      chk("xclk", bus.XCLK, (xn / (XCLK_DIV / 2)) % 2);
      if (bus.FIFOWR) begin
        wr_log.push_back(bus.FIFOIN);
        if (exp_q.size() == 0) begin
          chk("wr_when_none_expected", bus.FIFOWR, 32'h0);
        end else begin
          m_last = exp_q.pop_front();
          chk("fifoin", bus.FIFOIN, m_last);
        end
      end else begin
        chk("fifoin_hold", bus.FIFOIN, m_last);
      end
      if (bus.FRAME_DONE) done_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit full);
    cyc(1); bus.CAMDATA = d; bus.PCLK = 1'b0;
    cyc(4); bus.PCLK = 1'b1; bus.FIFOFULL = full;
    cyc(4); bus.FIFOFULL = 1'b0;
  endtask

  task automatic send_line(input logic [7:0] start, input logic [7:0] step, input int nb, input int drop_pix);
    logic [7:0] cur, nxt;
    cyc(1); bus.HREF = 1'b1;
    for (int i = 0; i < nb; i++) begin
      cur = 8'(start + i * step);
      nxt = 8'(start + (i + 1) * step);
      if (i % 2 == 0 && i + 1 < nb && m_in_frame && i / 2 != drop_pix)
        exp_q.push_back(fmt(m_mode, cur, nxt));
      send_byte(cur, (i % 2 == 1) && (i / 2 == drop_pix));
    end
    cyc(1); bus.PCLK = 1'b0;
    cyc(4); bus.HREF = 1'b0;
    cyc(8);
  endtask

  task automatic vsync_fall();
    cyc(1); bus.VSYNC = 1'b0;
    if (m_armed) begin
      m_armed = 1'b0; m_in_frame = 1'b1; m_mode = bus.MODE;
    end
    cyc(10);
  endtask

  task automatic vsync_rise();
    cyc(1); bus.VSYNC = 1'b1;
    if (m_in_frame) begin
      m_in_frame = 1'b0; m_armed = bus.CAPON;
    end
    cyc(10);
  endtask

  task automatic snap();
    cyc(1); bus.SNAP = 1'b1;
    if (!m_armed && !m_in_frame) m_armed = 1'b1;
    cyc(1); bus.SNAP = 1'b0;
  endtask

  task automatic set_capon(input bit v);
    cyc(1); bus.CAPON = v;
    if (v && !m_armed && !m_in_frame) m_armed = 1'b1;
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
  endtask

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: simulation exceeded its time budget");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    bus.CAPON = 0; bus.SNAP = 0; bus.MODE = 2'b00; bus.FIFOFULL = 0;
    bus.PCLK = 0; bus.HREF = 0; bus.VSYNC = 1; bus.CAMDATA = 8'h00;
    #1 RST = 1'b0;
    cyc(4);
    RST = 1'b1;
    cyc(4);

    // Single shot, RGB565, two lines of four pixels; a SNAP mid-frame must be ignored.
    w0 = wr_log.size(); d0 = done_cnt;
    snap(); cyc(2);
    chk("busy_after_snap", bus.BUSY, 1);
    vsync_fall();
    snap();
    send_line(8'h12, 8'h22, 8, -1);
    send_line(8'h22, 8'h22, 8, -1);
    vsync_rise();
    chk("a_writes", wr_log.size() - w0, 8);
    chk("a_first_pix", wr_log[w0], 16'h1234);
    chk("a_last_pix", last_wr(), 16'hEE10);
    chk("a_done", done_cnt - d0, 1);
    chk("a_busy", bus.BUSY, 0);
    chk("a_pending", exp_q.size(), 0);

    // RGB444; MODE change after frame start must not take effect.
    bus.MODE = 2'b01;
    snap(); vsync_fall();
    bus.MODE = 2'b10;
    send_line(8'hAB, 8'h22, 2, -1);
    vsync_rise();
    chk("m01_pix", last_wr(), 16'h0BCD);

    // Y-only.
    snap(); vsync_fall();
    send_line(8'h5A, 8'h26, 2, -1);
    vsync_rise();
    chk("m10_pix", last_wr(), 16'h005A);

    // Continuous over three frames, CAPON dropped inside frame 2.
    bus.MODE = 2'b00;
    w0 = wr_log.size(); d0 = done_cnt;
    set_capon(1);
    vsync_fall(); send_line(8'h01, 8'h01, 4, -1); vsync_rise();
    vsync_fall(); set_capon(0); send_line(8'h11, 8'h01, 4, -1); vsync_rise();
    w1 = wr_log.size();
    vsync_fall(); send_line(8'h21, 8'h01, 4, -1); vsync_rise();
    chk("cont_done", done_cnt - d0, 2);
    chk("cont_writes", wr_log.size() - w0, 4);
    chk("cont_f3_writes", wr_log.size() - w1, 0);
    chk("cont_busy", bus.BUSY, 0);

    // FIFOFULL on the third pixel of a line.
    snap(); vsync_fall();
    w0 = wr_log.size();
    send_line(8'h30, 8'h01, 8, 2);
    chk("full_writes", wr_log.size() - w0, 3);
    chk("full_pix2", wr_log[w0+1], 16'h3233);
    chk("full_pix4", last_wr(), 16'h3637);
    chk("ovf_set", bus.OVERFLOW, 1);
    vsync_rise();
    chk("ovf_sticky", bus.OVERFLOW, 1);
    snap(); cyc(4);
    chk("ovf_wait_vs", bus.OVERFLOW, 1);
    vsync_fall();
    chk("ovf_cleared", bus.OVERFLOW, 0);

    // Odd trailing byte then an even line in the same frame.
    w0 = wr_log.size();
    send_line(8'h40, 8'h01, 5, -1);
    send_line(8'h50, 8'h01, 4, -1);
    chk("odd_writes", wr_log.size() - w0, 4);
    chk("odd_pix2", wr_log[w0+1], 16'h4243);
    chk("odd_next_line", wr_log[w0+2], 16'h5051);
    vsync_rise();

    // Capture requested mid-frame waits for the next VSYNC fall.
    vsync_fall();
    w0 = wr_log.size(); d0 = done_cnt;
    snap();
    send_line(8'h60, 8'h01, 4, -1);
    chk("midframe_no_writes", wr_log.size() - w0, 0);
    chk("midframe_busy", bus.BUSY, 1);
    vsync_rise();
    chk("midframe_no_done", done_cnt - d0, 0);
    vsync_fall();
    send_line(8'h70, 8'h01, 2, -1);
    vsync_rise();
    chk("midframe_pix", last_wr(), 16'h7071);
    chk("midframe_done", done_cnt - d0, 1);

    // Reset in the middle of a frame.
    snap(); vsync_fall();
    d0 = done_cnt;
    cyc(1); bus.HREF = 1'b1;
    exp_q.push_back(16'h8182);
    send_byte(8'h81, 0);
    send_byte(8'h82, 0);
    cyc(6);
    chk("pre_reset_pix", last_wr(), 16'h8182);
    RST = 1'b0;
    m_last = 16'h0; m_in_frame = 1'b0; m_armed = 1'b0;
    exp_q.delete();
    cyc(3);
    RST = 1'b1;
    @(negedge CLK); chk("xclk_restart", bus.XCLK, 0);
    repeat (2) @(negedge CLK); chk("xclk_rise", bus.XCLK, 1);
    repeat (2) @(negedge CLK); chk("xclk_fall", bus.XCLK, 0);
    cyc(1); bus.PCLK = 1'b0;
    cyc(4); bus.HREF = 1'b0;
    cyc(4);
    vsync_rise();
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_ovf", bus.OVERFLOW, 0);
    chk("final_pending", exp_q.size(), 0);

    summary();
    $finish;
  end
endmodule
